// File: rtl/sobel_pkg.sv
// -----------------------------------------------------------------------------
// sobel_pkg
// Shared definitions for the Sobel write-back stage:
//   - default image geometry (W, H, K) and the derived output size (OW, OH, N)
//   - FSM state encoding (IDLE/RUN/DRAIN/DONE) and its enum wrapper
//   - pixel values written for edge / non-edge results
// -----------------------------------------------------------------------------
package sobel_pkg;

    localparam int DEF_W  = 220;
    localparam int DEF_H  = 220;
    localparam int DEF_K  = 3;
    localparam int DEF_OW = DEF_W - DEF_K + 1;
    localparam int DEF_OH = DEF_H - DEF_K + 1;
    localparam int DEF_N  = DEF_OW * DEF_OH;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_RUN   = RUN,
        ST_DRAIN = DRAIN,
        ST_DONE  = DONE
    } state_e;

    localparam logic [7:0] EDGE_VAL = 8'hFF;
    localparam logic [7:0] FLAT_VAL = 8'h00;

    // Number of valid-convolution results for a w x h image and k x k kernel.
    function automatic int out_pixels(input int w, input int h, input int k);
        return (w - k + 1) * (h - k + 1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a registered head entry (show-ahead): dout always
// holds the oldest entry while the FIFO is non-empty, and reads as zero after
// reset or once the last entry has been popped.
//   clk    in   clock
//   reset  in   asynchronous, active-high
//   push   in   write din (caller guarantees !full || pop)
//   pop    in   discard the head entry (caller guarantees !empty)
//   din    in   WIDTH  entry to write
//   dout   out  WIDTH  registered head entry
//   full   out  DEPTH entries held
//   empty  out  no entries held
//   count  out  number of entries held
// DEPTH must be a power of two, at least 2, so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int         PW       = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = 1;
    localparam logic [PW:0]   CNT_ONE  = 1;
    localparam logic [PW:0]   CNT_FULL = DEPTH[PW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, wr_ptr_q, rd_next;
    logic [PW:0]      count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;

    assign rd_next = rd_ptr_q + PTR_ONE;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        head_d  = head_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end
        // The next head is either the entry behind the one leaving, the
        // incoming word when it lands in an empty (or emptying) FIFO, or zero.
        if (pop) begin
            if (count_q > CNT_ONE) begin
                head_d = mem_q[rd_next];
            end else if (push) begin
                head_d = din;
            end else begin
                head_d = '0;
            end
        end else if (push && count_q == '0) begin
            head_d = din;
        end
    end

    // NOTE: the storage array has no reset; only pointers, count and the head
    // register are cleared, which is enough to make every entry invalid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values present before the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_next;
            count_q <= count_d;
            head_q  <= head_d;
        end
    end

    assign dout  = head_q;
    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/sobel_writeback.sv
// -----------------------------------------------------------------------------
// sobel_writeback
// Thresholds the convolution magnitude stream, tags each result with its
// row-major output address and queues it for the result memory.
//   clk         in   clock
//   reset       in   asynchronous, active-high
//   pxl_in      in   8   convolution magnitude
//   pxl_valid   in   1   magnitude valid (no upstream stall)
//   start       in   1   begin a frame (only honoured when idle)
//   mem_ready   in   1   memory accepts the current write
//   mem_we      out  1   write request (FIFO non-empty)
//   mem_addr    out  AW  address of the FIFO head
//   mem_data    out  8   FF for edge, 00 otherwise
//   edge_count  out  16  edges seen this frame
//   overflow    out  1   sticky: a result was dropped
//   busy        out  1   frame in progress
//   frame_done  out  1   one-cycle completion pulse
// -----------------------------------------------------------------------------
module sobel_writeback
    import sobel_pkg::*;
#(
    parameter int         W      = DEF_W,
    parameter int         H      = DEF_H,
    parameter int         K      = DEF_K,
    parameter logic [7:0] THRESH = 8'd64,
    parameter int         DEPTH  = 4,
    parameter int         AW     = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    pxl_in,
    input  logic          pxl_valid,
    input  logic          start,
    input  logic          mem_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_data,
    output logic [15:0]   edge_count,
    output logic          overflow,
    output logic          busy,
    output logic          frame_done
);

    localparam int          N        = out_pixels(W, H, K);
    localparam int          FW       = AW + 8;
    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);
    localparam logic [AW-1:0] IDX_ONE  = 1;

    state_e          state_q, state_d;
    logic [AW-1:0]   wr_idx_q, wr_idx_d;
    logic [15:0]     edge_cnt_q, edge_cnt_d;
    logic            ovf_q, ovf_d;

    logic            fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [FW-1:0]   fifo_dout;

    logic            sample, is_edge, pop, push;
    logic [7:0]      res_data;

    assign sample   = (state_q == ST_RUN) && pxl_valid;
    assign is_edge  = (pxl_in >= THRESH);
    assign res_data = is_edge ? EDGE_VAL : FLAT_VAL;
    assign pop      = !fifo_empty && mem_ready;
    // A full FIFO can still take a sample when the head leaves this cycle.
    assign push     = sample && (!fifo_full || pop);

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({wr_idx_q, res_data}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d    = state_q;
        wr_idx_d   = wr_idx_q;
        edge_cnt_d = edge_cnt_q;
        ovf_d      = ovf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    wr_idx_d   = '0;
                    edge_cnt_d = '0;
                    ovf_d      = 1'b0;
                end
            end
            ST_RUN: begin
                if (pxl_valid) begin
                    // Dropped samples still advance the address and count
                    // edges, so the image geometry stays intact.
                    wr_idx_d = wr_idx_q + IDX_ONE;
                    if (is_edge) edge_cnt_d = edge_cnt_q + 16'd1;
                    if (!push)   ovf_d      = 1'b1;
                    if (wr_idx_q == LAST_IDX) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_count == '0) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wr_idx_q   <= '0;
            edge_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_idx_q   <= wr_idx_d;
            edge_cnt_q <= edge_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    assign mem_we     = !fifo_empty;
    assign mem_addr   = fifo_dout[FW-1:8];
    assign mem_data   = fifo_dout[7:0];
    assign edge_count = edge_cnt_q;
    assign overflow   = ovf_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_sobel_writeback.sv
module tb_sobel_writeback;

    localparam int         W      = 6;
    localparam int         H      = 6;
    localparam int         K      = 3;
    localparam int         N      = 16;
    localparam int         DEPTH  = 4;
    localparam int         AW     = 16;
    localparam logic [7:0] THRESH = 8'd64;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    pxl_in;
    logic          pxl_valid, start, mem_ready;
    logic          mem_we, overflow, busy, frame_done;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic [15:0]   edge_count;

    always #5 clk = ~clk;

    sobel_writeback #(
        .W(W), .H(H), .K(K), .THRESH(THRESH), .DEPTH(DEPTH), .AW(AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pxl_in     (pxl_in),
        .pxl_valid  (pxl_valid),
        .start      (start),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .edge_count (edge_count),
        .overflow   (overflow),
        .busy       (busy),
        .frame_done (frame_done)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model: queue of pending writes ----------------
    typedef struct {
        int         addr;
        logic [7:0] data;
    } wr_t;
    typedef enum {M_IDLE, M_RUN, M_DRAIN, M_DONE} mphase_e;

    wr_t     exp_q[$];
    mphase_e m_phase;
    int      m_idx, m_edges;
    bit      m_ovf;

    int         log_addr[$];
    logic [7:0] log_data[$];
    int         done_pulses = 0;
    int         we_cycles   = 0;

    task automatic model_clear();
        exp_q.delete();
        m_phase = M_IDLE;
        m_idx   = 0;
        m_edges = 0;
        m_ovf   = 0;
    endtask

    task automatic model_step();
        int occ;
        bit popped;
        occ    = exp_q.size();
        popped = (occ > 0) && mem_ready;
        if (popped) void'(exp_q.pop_front());
        case (m_phase)
            M_IDLE: if (start) begin
                m_phase = M_RUN;
                m_idx   = 0;
                m_edges = 0;
                m_ovf   = 0;
            end
            M_RUN: if (pxl_valid) begin
                wr_t w;
                w.addr = m_idx;
                w.data = (pxl_in >= 8'd64) ? 8'hFF : 8'h00;
                if (w.data == 8'hFF) m_edges++;
                if (occ < DEPTH || popped) exp_q.push_back(w);
                else m_ovf = 1;
                if (m_idx == N - 1) m_phase = M_DRAIN;
                m_idx++;
            end
            M_DRAIN: if (occ == 0) m_phase = M_DONE;
            M_DONE:  m_phase = M_IDLE;
            default: m_phase = M_IDLE;
        endcase
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) model_clear();
        else       model_step();
    end

    // Output monitor, sampled away from the active edge.
    always @(negedge clk) begin
        check("mem_we", mem_we, exp_q.size() > 0);
        if (mem_we && exp_q.size() > 0) begin
            check("mem_addr", mem_addr, exp_q[0].addr);
            check("mem_data", mem_data, exp_q[0].data);
        end
        check("busy", busy, m_phase != M_IDLE);
        check("frame_done", frame_done, m_phase == M_DONE);
        check("edge_count", edge_count, m_edges);
        check("overflow", overflow, m_ovf);
        if (frame_done) done_pulses++;
        if (mem_we) we_cycles++;
        if (mem_we && mem_ready && !reset) begin
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_data);
        end
    end

    // ---------------- drivers ----------------
    task automatic step(input bit v, input logic [7:0] p, input bit rdy, input bit st);
        pxl_valid = v;
        pxl_in    = p;
        mem_ready = rdy;
        start     = st;
        @(posedge clk);
        #1;
    endtask

    task automatic begin_frame(input bit rdy);
        done_pulses = 0;
        log_addr.delete();
        log_data.delete();
        step(0, 8'd0, rdy, 1);
    endtask

    task automatic finish_frame(input string tag);
        int budget;
        budget = 0;
        while (busy && budget < 100) begin
            step(0, 8'd0, 1, 0);
            budget++;
        end
        check({tag, "_timeout"}, busy, 0);
        check({tag, "_done_pulses"}, done_pulses, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_data"}, mem_data, 0);
        check({tag, "_edge_count"}, edge_count, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_frame_done"}, frame_done, 0);
    endtask

    logic [7:0] px[N];
    int exp_edges;

    task automatic fill_pixels();
        for (int i = 0; i < N; i++) px[i] = 8'($urandom_range(0, 255));
        exp_edges = 0;
        for (int i = 0; i < N; i++) if (px[i] >= 8'd64) exp_edges++;
    endtask

    initial begin
        model_clear();
        reset = 1'b0; start = 1'b0; pxl_valid = 1'b0; pxl_in = 8'd0; mem_ready = 1'b0;

        // Reset asserted between clock edges: outputs clear without a clock.
        #2 reset = 1'b1;
        #1 check_reset_outputs("por");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Basic frame with the memory always ready.
        fill_pixels();
        px[0] = 8'd100; px[1] = 8'd64; px[2] = 8'd63; px[3] = 8'd0;
        exp_edges = 0;
        for (int i = 0; i < N; i++) if (px[i] >= 8'd64) exp_edges++;
        begin_frame(1);
        for (int i = 0; i < N; i++) step(1, px[i], 1, 0);
        finish_frame("basic");
        check("basic_edges", edge_count, exp_edges);
        check("basic_ovf", overflow, 0);
        check("basic_nwrites", log_addr.size(), N);
        for (int i = 0; i < N && i < log_addr.size(); i++) check("basic_addr", log_addr[i], i);
        if (log_data.size() >= 4) begin
            check("basic_d0", log_data[0], 8'hFF);
            check("basic_d1", log_data[1], 8'hFF);
            check("basic_d2", log_data[2], 8'h00);
            check("basic_d3", log_data[3], 8'h00);
        end

        // Back-pressure: six samples against a stalled memory.
        fill_pixels();
        begin_frame(0);
        for (int i = 0; i < 6; i++) step(1, px[i], 0, 0);
        check("bp_ovf_set", overflow, 1);
        for (int i = 6; i < N; i++) step(1, px[i], 1, 0);
        finish_frame("bp");
        check("bp_edges", edge_count, exp_edges);
        check("bp_ovf_hold", overflow, 1);
        check("bp_nwrites", log_addr.size(), N - 2);
        for (int i = 0; i < log_addr.size() && i < N - 2; i++)
            check("bp_addr", log_addr[i], (i < 4) ? i : i + 2);

        // Full FIFO with a pop in the same cycle as the incoming sample.
        fill_pixels();
        begin_frame(0);
        for (int i = 0; i < 4; i++) step(1, px[i], 0, 0);
        step(1, px[4], 1, 0);
        check("fp_ovf", overflow, 0);
        for (int i = 5; i < N; i++) step(1, px[i], 1, 0);
        finish_frame("fp");
        check("fp_ovf_end", overflow, 0);
        check("fp_nwrites", log_addr.size(), N);
        for (int i = 0; i < N && i < log_addr.size(); i++) check("fp_addr", log_addr[i], i);

        // Ignored inputs: valid while idle, start while running.
        we_cycles = 0;
        repeat (4) step(1, 8'hFF, 1, 0);
        check("idle_no_we", we_cycles, 0);
        fill_pixels();
        begin_frame(1);
        for (int i = 0; i < 5; i++) step(1, px[i], 1, 0);
        step(1, px[5], 1, 1);
        for (int i = 6; i < N - 1; i++) step(1, px[i], 1, 0);
        check("ign_busy_before_last", busy, 1);
        step(1, px[N-1], 1, 0);
        finish_frame("ign");
        check("ign_nwrites", log_addr.size(), N);
        for (int i = 0; i < N && i < log_addr.size(); i++) check("ign_addr", log_addr[i], i);

        // Reset in the middle of a frame with three entries buffered.
        fill_pixels();
        begin_frame(1);
        for (int i = 0; i < 6; i++) step(1, px[i], 1, 0);
        for (int i = 6; i < 8; i++) step(1, px[i], 0, 0);
        check("mid_pre_we", mem_we, 1);
        #2 reset = 1'b1;
        #1 check_reset_outputs("mid");
        @(posedge clk);
        #1 reset = 1'b0;
        we_cycles = 0;
        log_addr.delete();
        repeat (6) step(1'($urandom_range(0, 1)), 8'($urandom), 1, 0);
        check("mid_no_we", we_cycles, 0);
        check("mid_no_writes", log_addr.size(), 0);

        // Randomized frames; the first follows the mid-frame reset.
        for (int f = 0; f < 4; f++) begin
            int sent, budget;
            begin_frame(1'($urandom_range(0, 1)));
            sent = 0; budget = 0; exp_edges = 0;
            while (sent < N && budget < 500) begin
                bit         v;
                logic [7:0] p;
                v = ($urandom_range(0, 99) < 70);
                p = 8'($urandom_range(0, 255));
                if (v && p >= 8'd64) exp_edges++;
                if (v) sent++;
                step(v, p, $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 5);
                budget++;
            end
            finish_frame("rand");
            check("rand_edges", edge_count, exp_edges);
            check("rand_first_addr", (log_addr.size() > 0) ? log_addr[0] : -1, 0);
        end

        repeat (3) step(0, 8'd0, 1, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sobel_writeback.md
# sobel_writeback

Downstream stage of the 3x3 convolution engine. Takes the engine's absolute-value output pixel stream and its valid strobe, applies a binary edge threshold, and assigns each valid result a linear row-major address in the (W-K+1)x(H-K+1) output image. Results are buffered in a small FIFO so a slow result memory can back-pressure writes. The block also counts edge pixels and signals frame completion.

## Interface
Parameters:
- W, 220, input image width
- H, 220, input image height
- K, 3, kernel size; output image is OW=W-K+1 by OH=H-K+1, N=OW*OH results per frame
- THRESH, 8'd64, edge threshold
- DEPTH, 4, FIFO entries (power of 2)
- AW, 16, memory address width; must satisfy N <= 2^AW

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- pxl_in  in  8  convolution magnitude, sampled when pxl_valid=1
- pxl_valid  in  1  convolution valid strobe; no stall path upstream
- start  in  1  begin frame, sampled only in IDLE
- mem_ready  in  1  result memory accepts the current write
- mem_we  out  1  write request (FIFO non-empty)
- mem_addr  out  AW  address of FIFO head
- mem_data  out  8  data of FIFO head, 8'hFF edge / 8'h00 non-edge
- edge_count  out  16  edges seen this frame
- overflow  out  1  sticky: at least one result dropped
- busy  out  1  state is not IDLE
- frame_done  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: pxl_valid ignored. start=1 -> RUN; on the same edge, clear wr_idx, edge_count and overflow.
- RUN: each pxl_valid=1 sample is a result:
  - data = (pxl_in >= THRESH) ? 8'hFF : 8'h00; edge_count += 1 when data=FF (edges on dropped samples are counted too).
  - Push {wr_idx, data} to the FIFO.
  - wr_idx increments on every sample, dropped or not, so image geometry is preserved.
  - After the sample with wr_idx = N-1 -> DRAIN.
- DRAIN: pxl_valid ignored. When the FIFO is empty -> DONE.
- DONE: frame_done=1 for exactly one cycle, then -> IDLE. edge_count and overflow hold until the next start.
- Push is accepted when the FIFO is not full, or when a pop happens in the same cycle. Otherwise the sample is dropped and overflow is set to 1.
- Pop occurs when mem_we=1 and mem_ready=1.
- start outside IDLE is ignored.
- Reset at any time:
  - state = IDLE, FIFO emptied.
  - All outputs 0: mem_we, mem_addr, mem_data, edge_count, overflow, busy, frame_done.
  - The in-progress frame is abandoned and no further writes are issued.

## Timing
- A sample taken at edge t appears at the FIFO head with mem_we=1 from edge t+1 if the FIFO was empty (one-cycle latency).
- mem_addr and mem_data are stable while mem_we=1 and mem_ready=0.
- With mem_ready tied to 1, sustained throughput is one write per cycle and the FIFO never holds more than 1 entry.
- frame_done rises on the edge after the final pop completes (DRAIN -> DONE transition). busy falls one cycle later.
- edge_count is registered and updates the edge after the sample.

## Structure
- Shared package sobel_pkg holds:
  - W, H, K defaults.
  - Derived OW, OH, N.
  - State encoding as localparams: IDLE=0, RUN=1, DRAIN=2, DONE=3.
- Sub-module sync_fifo, parameterised DEPTH and WIDTH (=AW+8):
  - Ports: push, pop, din, dout, full, empty, count.
  - Same clk and asynchronous active-high reset.
  - dout is the registered head entry.

## Test plan
Bench uses W=H=6, K=3, so N=16, with THRESH=64 and DEPTH=4.
- Reset values: assert reset mid-cycle -> all outputs 0 immediately, without waiting for a clock edge.
- Basic frame, mem_ready=1:
  - start, then 16 valid samples 100,64,63,0,... -> writes at addr 0..15.
  - Data FF,FF,00,00,... (64 compares as an edge).
  - Final edge_count equals the number of samples >= 64.
  - frame_done is a single pulse, overflow=0.
- Back-pressure:
  - mem_ready=0 while 6 consecutive samples arrive.
  - The first 4 are buffered; samples at addr 4 and 5 are dropped and overflow=1.
  - Releasing mem_ready gives writes to addr 0..3, then 6..15.
- Full FIFO with simultaneous pop:
  - With the FIFO full, pulse mem_ready=1 in the same cycle as a valid sample.
  - The sample is accepted and overflow stays 0.
- Ignored inputs:
  - pxl_valid pulses in IDLE -> no mem_we.
  - start pulsed during RUN -> wr_idx is not reset and the frame completes at 16 samples.
- Reset mid-frame:
  - Reset after 8 samples with 3 buffered -> FIFO empty, no further mem_we.
  - A new start then produces addresses beginning at 0.
